// File: rtl/display_pkg.sv
// Shared constants and types for the four-digit multiplexed display scanner.
package display_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int NIBBLE_W   = 4;

  typedef logic [1:0] digit_idx_t;

  localparam digit_idx_t                LAST_IDX   = 2'd3;
  localparam logic [NUM_DIGITS-1:0]     AN_RST     = 4'b1111;
  localparam logic [NIBBLE_W-1:0]       DIGITO_RST = 4'h0;

  // Active-low one-hot enable for the selected digit.
  function automatic logic [NUM_DIGITS-1:0] an_onehot_low(input digit_idx_t idx);
    return ~(NUM_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/display_tick.sv
// Digit-slot prescaler: counts 0..PRESCALE-1 and pulses tick_o on the last count.
module display_tick #(
  parameter int PRESCALE = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int                CNT_W = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);
  assign cnt_d  = tick_o ? '0 : cnt_q + CNT_W'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/display_scan.sv
// Four-digit multiplexed display scanner with frame-synchronous shadow update.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module display_scan
  import display_pkg::*;
#(
  parameter int PRESCALE = 50000
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [15:0] valor,
  input  logic        carga,
  output logic        pronto,
  output logic [3:0]  digito,
  output logic [3:0]  an,
  output logic        apagado
);

  logic                  tick;
  logic                  boundary;
  digit_idx_t            idx_q, idx_d;
  logic [15:0]           shadow_q, shadow_d;
  logic [15:0]           pend_val_q, pend_val_d;
  logic                  pend_q, pend_d;
  logic                  pronto_q, pronto_d;
  logic [NIBBLE_W-1:0]   digito_q, digito_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  apagado_q, apagado_d;
  logic                  blank_d;
  logic [NIBBLE_W-1:0]   nib [NUM_DIGITS];

  display_tick #(.PRESCALE(PRESCALE)) u_tick (
    .clk_i  (Clock),
    .rst_ni (Resetn),
    .tick_o (tick)
  );

  assign boundary = tick && (idx_q == LAST_IDX);

  // Shadow only moves at the frame boundary, so a frame is never torn.
  always_comb begin
    idx_d      = tick ? idx_q + 2'd1 : idx_q;
    shadow_d   = shadow_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    if (boundary) begin
      if (carga)       shadow_d = valor;
      else if (pend_q) shadow_d = pend_val_q;
      pend_d = 1'b0;
    end else if (carga) begin
      pend_val_d = valor;
      pend_d     = 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
    assign nib[gi] = shadow_d[gi*NIBBLE_W +: NIBBLE_W];
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] upper_zero;
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_uz
    assign upper_zero[gi] = (shadow_d[NUM_DIGITS*NIBBLE_W-1 : gi*NIBBLE_W] == '0);
  end
  assign blank_d = (idx_d != '0) && upper_zero[idx_d];
`else
  assign blank_d = 1'b0;
`endif

  always_comb begin
    pronto_d  = !pend_d;
    digito_d  = digito_q;
    an_d      = an_q;
    apagado_d = apagado_q;
    if (tick) begin
      digito_d  = nib[idx_d];
      an_d      = blank_d ? AN_RST : an_onehot_low(idx_d);
      apagado_d = blank_d;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      idx_q      <= '0;
      shadow_q   <= '0;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      pronto_q   <= 1'b1;
      digito_q   <= DIGITO_RST;
      an_q       <= AN_RST;
      apagado_q  <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      pronto_q   <= pronto_d;
      digito_q   <= digito_d;
      an_q       <= an_d;
      apagado_q  <= apagado_d;
    end
  end

  assign pronto  = pronto_q;
  assign digito  = digito_q;
  assign an      = an_q;
  assign apagado = apagado_q;

endmodule
